mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
Parametrised successor to the memory-reader datapath. Adds its own controller with a start/done handshake, mode select, latched base addresses, and a configurable filter count, filter size and image size. It reads 32-bit words from the shared read-only memory over a pipelined one-cycle-latency port and unpacks them into an image byte buffer and NUM_FILTERS filter byte buffers. It sits between the memory and the convolution datapath, which consumes the flattened buffers once the valid flags are set.

Parameters:
ADR_W, 8, memory word-address width; all address arithmetic wraps modulo 2^ADR_W.
NUM_FILTERS, 4, number of filter buffers.
FILTER_SIZE, 16, bytes per filter; must be a multiple of 4 (FW = FILTER_SIZE/4 words).
IMG_SIZE, 16, image side in bytes; IMG_SIZE*IMG_SIZE must be a multiple of 4 (IW = IMG_SIZE*IMG_SIZE/4 words).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
start  in  1  request a load; sampled only in IDLE.
mode  in  2  00 none, 01 filters only, 10 image only, 11 filters then image.
filt_base  in  ADR_W  word address of filter 0.
img_base  in  ADR_W  word address of image word 0.
mem_rd_en  out  1  read strobe.
mem_rd_adr  out  ADR_W  read word address.
mem_rd_data  in  32  read data, valid exactly one cycle after the strobe.
busy  out  1  load in progress.
done  out  1  one-cycle completion pulse.
filt_valid  out  1  filter buffers hold a complete load.
img_valid  out  1  image buffer holds a complete load.
img_data  out  8*IMG_SIZE*IMG_SIZE  image bytes; byte i occupies bits [8i+7:8i].
filters  out  8*NUM_FILTERS*FILTER_SIZE  filter f, byte j at flat index f*FILTER_SIZE+j.

Behaviour:
- Reset (asynchronous, rst=0):
  - FSM goes to IDLE.
  - busy, done, mem_rd_en, filt_valid and img_valid go to 0.
  - mem_rd_adr goes to 0.
  - All buffer bytes go to 0.
  - Any load in progress is abandoned, including mid-operation.
- FSM states: IDLE, LOAD_FILT, LOAD_IMG, DRAIN, DONE.
- IDLE:
  - start=1 with mode!=00 latches mode, filt_base and img_base.
  - Next state is LOAD_FILT if mode[0]=1, otherwise LOAD_IMG.
  - If mode[0]=1, filt_valid is cleared on that edge; if mode[1]=1, img_valid is cleared on that edge.
  - start with mode=00 is ignored.
- LOAD_FILT:
  - One read per cycle: mem_rd_en=1, mem_rd_adr = filt_base + f*FW + w.
  - w runs 0..FW-1 inner; f runs 0..NUM_FILTERS-1 outer.
  - After the last word, go to LOAD_IMG if mode[1]=1, otherwise DRAIN.
- LOAD_IMG:
  - One read per cycle: mem_rd_en=1, mem_rd_adr = img_base + w, for w = 0..IW-1.
  - After the last word, go to DRAIN.
- Write-back:
  - The destination of each read is registered with the strobe.
  - On the following cycle, mem_rd_data[8k+7:8k] is written to byte 4w+k (k=0..3) of the selected buffer.
  - There are no bubbles between the filter and image phases.
- DRAIN: mem_rd_en=0; the last word is written; filt_valid and/or img_valid are set per the latched mode.
- DONE: done=1 for exactly one cycle; next state is IDLE.
- busy is 1 in LOAD_FILT, LOAD_IMG and DRAIN, and 0 in IDLE and DONE.
- mem_rd_adr holds its last value while mem_rd_en=0.
- start while busy or in DONE is ignored. Mode and base changes mid-load have no effect.
- Latency: let N = total words (NUM_FILTERS*FW and/or IW).
  - Start is sampled at edge 0.
  - Reads are issued in cycles 1..N.
  - The last write lands at edge N+1.
  - done is high in cycle N+2.
  - A new start is accepted at edge N+3.
- Buffers not selected by the mode keep their contents. A reload does not pre-clear; bytes are overwritten as they arrive.
- Address wrap: base + offset beyond 2^ADR_W-1 wraps to 0.

Test Plan:
Memory model for all scenarios: word at address a returns bytes {4a+3, 4a+2, 4a+1, 4a} mod 256.
- Reset values: hold rst=0 → all outputs and buffer bytes read 0; release rst, no start → state stays IDLE, mem_rd_en=0.
- Mode 11, defaults, filt_base=0x00, img_base=0x40, start at edge 0:
  - 80 consecutive reads, adr 0x00..0x0F then 0x40..0x7F;
  - done high only in cycle 82;
  - filters byte f*16+j = 16f+j;
  - img_data byte i = i mod 256;
  - both valid flags = 1.
- Mode 10 after the previous load, img_base=0x00 → 64 reads at adr 0x00..0x3F; img_valid drops at the start edge and rises at DRAIN; filters unchanged; filt_valid stays 1.
- Mode 01, filt_base=0xFE → addresses 0xFE, 0xFF, 0x00, 0x01, ... (wrap); filter 0 bytes = 0xF8..0xFF, 0x00..0x07.
- Pulse start (mode 11) at cycle 10 of a load, and with mode 00 in IDLE → no effect; read sequence and done timing unchanged; no done for mode 00.
- Assert rst=0 mid-load at read 30, release, restart mode 11 → flags 0 and buffers 0 immediately; the restarted load completes correctly with done in cycle 82 after its start edge.

Source files
------------

// File: rtl/mem_loader_if.sv
// mem_loader_if: read-only word memory port.
// Read data is valid exactly one cycle after the strobe.
interface mem_loader_if #(
   parameter int ADR_W = 8
);
   logic             mem_rd_en;
   logic [ADR_W-1:0] mem_rd_adr;
   logic [31:0]      mem_rd_data;

   modport master (
      output mem_rd_en,
      output mem_rd_adr,
      input  mem_rd_data
   );

   modport slave (
      input  mem_rd_en,
      input  mem_rd_adr,
      output mem_rd_data
   );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: start/done controller that streams words from memory
// and unpacks them into filter and image byte buffers.
module mem_loader #(
   parameter int ADR_W       = 8,
   parameter int NUM_FILTERS = 4,
   parameter int FILTER_SIZE = 16,
   parameter int IMG_SIZE    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [1:0]                           mode,
   input  logic [ADR_W-1:0]                     filt_base,
   input  logic [ADR_W-1:0]                     img_base,
   mem_loader_if.master                         mem,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 filt_valid,
   output logic                                 img_valid,
   output logic [8*IMG_SIZE*IMG_SIZE-1:0]       img_data,
   output logic [8*NUM_FILTERS*FILTER_SIZE-1:0] filters
);
   localparam int FW   = FILTER_SIZE / 4;
   localparam int NFW  = NUM_FILTERS * FW;
   localparam int IW   = IMG_SIZE * IMG_SIZE / 4;
   localparam int MAXW = (NFW > IW) ? NFW : IW;
   localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

   typedef enum logic [2:0] {
      IDLE, LOAD_FILT, LOAD_IMG, DRAIN, DONE
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [ADR_W-1:0] ibase_q, ibase_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fv_q, fv_d;
   logic             iv_q, iv_d;
   logic             wr_vld_q;
   logic             wr_img_q;
   logic [CW-1:0]    wr_idx_q;
   logic [8*IMG_SIZE*IMG_SIZE-1:0]       img_q;
   logic [8*NUM_FILTERS*FILTER_SIZE-1:0] flt_q;
   logic             rd_en;

   // Filter words are contiguous, so one counter covers f*FW+w.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      ibase_d = ibase_q;
      adr_d   = adr_q;
      cnt_d   = cnt_q;
      fv_d    = fv_q;
      iv_d    = iv_q;
      unique case (state_q)
         IDLE: begin
            if (start && (mode != 2'b00)) begin
               mode_d  = mode;
               ibase_d = img_base;
               cnt_d   = '0;
               if (mode[0]) begin
                  state_d = LOAD_FILT;
                  adr_d   = filt_base;
                  fv_d    = 1'b0;
               end else begin
                  state_d = LOAD_IMG;
                  adr_d   = img_base;
               end
               if (mode[1]) iv_d = 1'b0;
            end
         end
         LOAD_FILT: begin
            cnt_d = cnt_q + CW'(1);
            adr_d = adr_q + ADR_W'(1);
            if (cnt_q == CW'(NFW - 1)) begin
               cnt_d = '0;
               if (mode_q[1]) begin
                  state_d = LOAD_IMG;
                  adr_d   = ibase_q;
               end else begin
                  state_d = DRAIN;
                  adr_d   = adr_q;
               end
            end
         end
         LOAD_IMG: begin
            cnt_d = cnt_q + CW'(1);
            adr_d = adr_q + ADR_W'(1);
            if (cnt_q == CW'(IW - 1)) begin
               cnt_d   = '0;
               state_d = DRAIN;
               adr_d   = adr_q;
            end
         end
         DRAIN: begin
            state_d = DONE;
            if (mode_q[0]) fv_d = 1'b1;
            if (mode_q[1]) iv_d = 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         mode_q   <= 2'b00;
         ibase_q  <= '0;
         adr_q    <= '0;
         cnt_q    <= '0;
         fv_q     <= 1'b0;
         iv_q     <= 1'b0;
         wr_vld_q <= 1'b0;
         wr_img_q <= 1'b0;
         wr_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         ibase_q  <= ibase_d;
         adr_q    <= adr_d;
         cnt_q    <= cnt_d;
         fv_q     <= fv_d;
         iv_q     <= iv_d;
         wr_vld_q <= rd_en;
         wr_img_q <= (state_q == LOAD_IMG);
         wr_idx_q <= cnt_q;
      end
   end

   // Word w lands little-endian at bytes 4w..4w+3 of its buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         img_q <= '0;
         flt_q <= '0;
      end else if (wr_vld_q) begin
         if (wr_img_q) img_q[{wr_idx_q, 5'b0} +: 32] <= mem.mem_rd_data;
         else          flt_q[{wr_idx_q, 5'b0} +: 32] <= mem.mem_rd_data;
      end
   end

   assign rd_en = (state_q == LOAD_FILT) || (state_q == LOAD_IMG);

   assign mem.mem_rd_en  = rd_en;
   assign mem.mem_rd_adr = adr_q;
   assign busy       = rd_en || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign filt_valid = fv_q;
   assign img_valid  = iv_q;
   assign img_data   = img_q;
   assign filters    = flt_q;
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized self-checking bench for mem_loader against
// a behavioural load model and an address-pattern memory.
module tb_mem_loader;
   localparam int ADR_W = 8;
   localparam int NF    = 4;
   localparam int FS    = 16;
   localparam int IS    = 16;
   localparam int FW    = FS / 4;
   localparam int NFW   = NF * FW;
   localparam int IW    = IS * IS / 4;
   localparam int IB    = IS * IS;
   localparam int FB    = NF * FS;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [ADR_W-1:0] filt_base = '0;
   logic [ADR_W-1:0] img_base = '0;
   logic             busy, done, filt_valid, img_valid;
   logic [8*IB-1:0]  img_data;
   logic [8*FB-1:0]  filters;

   mem_loader_if #(.ADR_W(ADR_W)) mem ();

   mem_loader #(
      .ADR_W(ADR_W), .NUM_FILTERS(NF), .FILTER_SIZE(FS), .IMG_SIZE(IS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .filt_base(filt_base), .img_base(img_base), .mem(mem.master),
      .busy(busy), .done(done), .filt_valid(filt_valid),
      .img_valid(img_valid), .img_data(img_data), .filters(filters)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [ADR_W-1:0] a, input int k);
      return 8'(4 * int'(a) + k);
   endfunction

   always @(posedge clk)
      if (mem.mem_rd_en)
         mem.mem_rd_data <= {pat(mem.mem_rd_adr, 3), pat(mem.mem_rd_adr, 2),
                             pat(mem.mem_rd_adr, 1), pat(mem.mem_rd_adr, 0)};

   int pos_cnt = 0;
   int p0 = 0;
   int compared = 0;
   int failed = 0;
   int rd_cyc[$];
   logic [ADR_W-1:0] rd_adr[$];
   int done_cyc[$];

   always @(posedge clk) pos_cnt <= pos_cnt + 1;

   always @(negedge clk) begin
      if (mem.mem_rd_en) begin
         rd_cyc.push_back(pos_cnt);
         rd_adr.push_back(mem.mem_rd_adr);
      end
      if (done) done_cyc.push_back(pos_cnt);
   end

   // Reference model: buffer contents, flags, expected read addresses.
   logic [7:0] m_img[IB];
   logic [7:0] m_flt[FB];
   logic m_fv, m_iv;
   logic [ADR_W-1:0] exp_a[$];

   function automatic void model_clear();
      for (int i = 0; i < IB; i++) m_img[i] = 8'h00;
      for (int i = 0; i < FB; i++) m_flt[i] = 8'h00;
      m_fv = 1'b0;
      m_iv = 1'b0;
   endfunction

   function automatic int model_load(input logic [1:0] m,
                                     input logic [ADR_W-1:0] fb,
                                     input logic [ADR_W-1:0] ib);
      logic [ADR_W-1:0] a;
      exp_a.delete();
      if (m[0])
         for (int f = 0; f < NF; f++)
            for (int w = 0; w < FW; w++) begin
               a = fb + ADR_W'(f * FW + w);
               exp_a.push_back(a);
               for (int k = 0; k < 4; k++) m_flt[f * FS + 4 * w + k] = pat(a, k);
            end
      if (m[1])
         for (int w = 0; w < IW; w++) begin
            a = ib + ADR_W'(w);
            exp_a.push_back(a);
            for (int k = 0; k < 4; k++) m_img[4 * w + k] = pat(a, k);
         end
      if (m[0]) m_fv = 1'b1;
      if (m[1]) m_iv = 1'b1;
      return exp_a.size();
   endfunction

   function automatic int bad_reads();
      int n;
      n = (rd_adr.size() > exp_a.size()) ? rd_adr.size() - exp_a.size()
                                         : exp_a.size() - rd_adr.size();
      for (int i = 0; i < rd_adr.size() && i < exp_a.size(); i++)
         if (rd_adr[i] !== exp_a[i] || rd_cyc[i] - p0 != i + 1) n++;
      return n;
   endfunction

   function automatic int bad_bufs();
      int n = 0;
      for (int i = 0; i < IB; i++) if (img_data[8*i +: 8] !== m_img[i]) n++;
      for (int i = 0; i < FB; i++) if (filters[8*i +: 8] !== m_flt[i]) n++;
      return n;
   endfunction

   function automatic int done_rel();
      if (done_cyc.size() != 1) return -done_cyc.size() - 1;
      return done_cyc[0] - p0;
   endfunction

   task automatic clear_log();
      rd_cyc.delete();
      rd_adr.delete();
      done_cyc.delete();
   endtask

   // Start sampled at edge 0; returns in cycle 1 with inputs scrambled.
   task automatic launch(input logic [1:0] m, input logic [ADR_W-1:0] fb,
                         input logic [ADR_W-1:0] ib);
      @(negedge clk);
      #1;
      clear_log();
      p0 = pos_cnt;
      start = 1'b1;
      mode = m;
      filt_base = fb;
      img_base = ib;
      @(negedge clk);
      #1;
      start = 1'b0;
      mode = 2'($urandom);
      filt_base = ADR_W'($urandom);
      img_base = ADR_W'($urandom);
   endtask

   task automatic run_to(input int rel);
      while (pos_cnt - p0 < rel) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      compared++;
      if ({busy, done, mem.mem_rd_en, filt_valid, img_valid} !== 5'b0) begin
         failed++;
         $display("FAIL reset_flags got=%b exp=00000",
                  {busy, done, mem.mem_rd_en, filt_valid, img_valid});
      end
      compared++;
      if (mem.mem_rd_adr !== '0) begin
         failed++;
         $display("FAIL reset_adr got=%h exp=00", mem.mem_rd_adr);
      end
      compared++;
      if (bad_bufs() != 0) begin
         failed++;
         $display("FAIL reset_bufs got=%0d bad bytes exp=0", bad_bufs());
      end
      #1 rst = 1'b1;
      clear_log();
      repeat (4) @(negedge clk);
      #1;
      compared++;
      if (rd_adr.size() != 0 || busy !== 1'b0 || mem.mem_rd_en !== 1'b0) begin
         failed++;
         $display("FAIL idle_quiet got reads=%0d busy=%b exp reads=0 busy=0",
                  rd_adr.size(), busy);
      end
   endtask

   task automatic test_mode11();
      int n, bad;
      n = model_load(2'b11, 8'h00, 8'h40);
      launch(2'b11, 8'h00, 8'h40);
      run_to(n + 4);
      compared++;
      if (bad_reads() != 0) begin
         failed++;
         $display("FAIL m11_reads got=%0d bad exp=0", bad_reads());
      end
      compared++;
      if (done_rel() != 82) begin
         failed++;
         $display("FAIL m11_done got=%0d exp=82", done_rel());
      end
      bad = 0;
      for (int f = 0; f < NF; f++)
         for (int j = 0; j < FS; j++)
            if (filters[8*(f*FS+j) +: 8] !== 8'(16 * f + j)) bad++;
      for (int i = 0; i < IB; i++) if (img_data[8*i +: 8] !== 8'(i)) bad++;
      compared++;
      if (bad != 0) begin
         failed++;
         $display("FAIL m11_bytes got=%0d bad exp=0", bad);
      end
      compared++;
      if ({filt_valid, img_valid} !== 2'b11) begin
         failed++;
         $display("FAIL m11_valid got=%b exp=11", {filt_valid, img_valid});
      end
   endtask

   task automatic test_mode10();
      int n;
      n = model_load(2'b10, 8'h00, 8'h00);
      launch(2'b10, 8'h00, 8'h00);
      compared++;
      if ({filt_valid, img_valid} !== 2'b10) begin
         failed++;
         $display("FAIL m10_clear got=%b exp=10", {filt_valid, img_valid});
      end
      run_to(n + 1);
      compared++;
      if (img_valid !== 1'b0) begin
         failed++;
         $display("FAIL m10_drain got=%b exp=0", img_valid);
      end
      run_to(n + 2);
      compared++;
      if (img_valid !== 1'b1 || filt_valid !== 1'b1) begin
         failed++;
         $display("FAIL m10_set got=%b exp=11", {filt_valid, img_valid});
      end
      run_to(n + 4);
      compared++;
      if (bad_reads() != 0 || done_rel() != n + 2) begin
         failed++;
         $display("FAIL m10_seq got bad=%0d done=%0d exp 0/%0d",
                  bad_reads(), done_rel(), n + 2);
      end
      compared++;
      if (bad_bufs() != 0) begin
         failed++;
         $display("FAIL m10_bufs got=%0d bad exp=0", bad_bufs());
      end
   endtask

   task automatic test_wrap();
      int n;
      n = model_load(2'b01, 8'hFE, 8'h00);
      launch(2'b01, 8'hFE, 8'h00);
      run_to(n + 4);
      compared++;
      if (bad_reads() != 0 || done_rel() != n + 2) begin
         failed++;
         $display("FAIL wrap_seq got bad=%0d done=%0d exp 0/%0d",
                  bad_reads(), done_rel(), n + 2);
      end
      compared++;
      if (filters[7:0] !== 8'hF8 || filters[8*8 +: 8] !== 8'h00 ||
          filters[8*15 +: 8] !== 8'h07) begin
         failed++;
         $display("FAIL wrap_f0 got=%h,%h,%h exp=f8,00,07",
                  filters[7:0], filters[8*8 +: 8], filters[8*15 +: 8]);
      end
      compared++;
      if (bad_bufs() != 0 || {filt_valid, img_valid} !== {m_fv, m_iv}) begin
         failed++;
         $display("FAIL wrap_bufs got=%0d bad flags=%b exp 0/%b",
                  bad_bufs(), {filt_valid, img_valid}, {m_fv, m_iv});
      end
   endtask

   task automatic test_ignore();
      int n;
      logic [ADR_W-1:0] fb, ib;
      fb = ADR_W'($urandom);
      ib = ADR_W'($urandom);
      n = model_load(2'b11, fb, ib);
      launch(2'b11, fb, ib);
      run_to(10);
      start = 1'b1;
      mode = 2'b11;
      run_to(11);
      start = 1'b0;
      run_to(n + 2);
      start = 1'b1;
      mode = 2'b11;
      run_to(n + 3);
      start = 1'b0;
      run_to(n + 8);
      compared++;
      if (bad_reads() != 0 || done_rel() != n + 2) begin
         failed++;
         $display("FAIL ign_seq got bad=%0d done=%0d exp 0/%0d",
                  bad_reads(), done_rel(), n + 2);
      end
      compared++;
      if (bad_bufs() != 0) begin
         failed++;
         $display("FAIL ign_bufs got=%0d bad exp=0", bad_bufs());
      end
      clear_log();
      start = 1'b1;
      mode = 2'b00;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      compared++;
      if (rd_adr.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL m00_ignored got reads=%0d dones=%0d exp 0/0",
                  rd_adr.size(), done_cyc.size());
      end
   endtask

   task automatic test_reset_mid();
      int n;
      launch(2'b11, ADR_W'($urandom), ADR_W'($urandom));
      run_to(30);
      rst = 1'b0;
      model_clear();
      #1;
      compared++;
      if ({busy, mem.mem_rd_en, filt_valid, img_valid} !== 4'b0 || bad_bufs() != 0) begin
         failed++;
         $display("FAIL midrst got flags=%b bad=%0d exp 0000/0",
                  {busy, mem.mem_rd_en, filt_valid, img_valid}, bad_bufs());
      end
      @(negedge clk);
      #1 rst = 1'b1;
      n = model_load(2'b11, 8'h00, 8'h40);
      launch(2'b11, 8'h00, 8'h40);
      run_to(n + 4);
      compared++;
      if (bad_reads() != 0 || done_rel() != 82) begin
         failed++;
         $display("FAIL midrst_seq got bad=%0d done=%0d exp 0/82",
                  bad_reads(), done_rel());
      end
      compared++;
      if (bad_bufs() != 0 || {filt_valid, img_valid} !== 2'b11) begin
         failed++;
         $display("FAIL midrst_bufs got=%0d bad flags=%b exp 0/11",
                  bad_bufs(), {filt_valid, img_valid});
      end
   endtask

   task automatic test_random();
      int n;
      logic [1:0] m;
      logic [ADR_W-1:0] fb, ib;
      for (int it = 0; it < 8; it++) begin
         m = 2'($urandom_range(1, 3));
         fb = ADR_W'($urandom);
         ib = ADR_W'($urandom);
         n = model_load(m, fb, ib);
         launch(m, fb, ib);
         run_to(n + 4);
         compared++;
         if (bad_reads() != 0 || done_rel() != n + 2) begin
            failed++;
            $display("FAIL rnd%0d_seq m=%b got bad=%0d done=%0d exp 0/%0d",
                     it, m, bad_reads(), done_rel(), n + 2);
         end
         compared++;
         if (bad_bufs() != 0 || {filt_valid, img_valid} !== {m_fv, m_iv}) begin
            failed++;
            $display("FAIL rnd%0d_bufs m=%b got=%0d bad flags=%b exp 0/%b",
                     it, m, bad_bufs(), {filt_valid, img_valid}, {m_fv, m_iv});
         end
      end
   endtask

   initial begin
      test_reset();
      test_mode11();
      test_mode10();
      test_wrap();
      test_ignore();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
